// File: rtl/pe_scheduler.sv
// pe_scheduler: sequences one PE job -- config latch, filter/ifmap/ipsum streams from the GLB
// through a one-word buffer, then opsum write-back, repeated per output column.
module pe_scheduler (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [12:0] cfg,
   input  logic [11:0] filter_base,
   input  logic [11:0] ifmap_base,
   input  logic [11:0] ipsum_base,
   input  logic [11:0] opsum_base,
   output logic        busy,
   output logic        done,
   output logic        mem_rd_en,
   output logic [11:0] mem_raddr,
   input  logic [31:0] mem_rdata,
   output logic        mem_we,
   output logic [11:0] mem_waddr,
   output logic [31:0] mem_wdata,
   output logic        pe_en,
   output logic [12:0] pe_config,
   output logic [31:0] pe_data,
   output logic        filter_valid,
   output logic        ifmap_valid,
   output logic        ipsum_valid,
   input  logic        filter_ready,
   input  logic        ifmap_ready,
   input  logic        ipsum_ready,
   input  logic [31:0] opsum,
   input  logic        opsum_valid,
   output logic        opsum_ready
);
   typedef enum logic [2:0] {IDLE, CFG, FILTER, IFMAP, IPSUM, OPSUM, DONE} state_t;
   state_t      state_q, state_d;
   logic [12:0] cfg_q, cfg_d;
   logic [11:0] fb_q, fb_d, ib_q, ib_d, pb_q, pb_d, ob_q, ob_d;
   logic [11:0] fi_q, fi_d, ii_q, ii_d, pi_q, pi_d, oi_q, oi_d;
   logic [4:0]  left_q, left_d, col_q, col_d;
   logic        pend_q, pend_d, full_q, full_d;
   logic [31:0] buf_q, buf_d;
   logic [2:0]  rs, p, np;
   logic [4:0]  nf, nc;
   logic        stream, rdy, hs, wr, rd, last;
   always_comb begin
      rs = {1'b0, cfg_q[11:10]} + 3'd1;
      p = {1'b0, cfg_q[8:7]} + 3'd1;
      np = cfg_q[12] ? {1'b0, cfg_q[1:0]} + 3'd1 : p;
      nf = {2'b0, p} * {2'b0, rs};
      nc = cfg_q[6:2];
      stream = state_q inside {FILTER, IFMAP, IPSUM};
      rdy = state_q == FILTER ? filter_ready : state_q == IFMAP ? ifmap_ready : ipsum_ready;
      hs = stream && full_q && rdy;
      wr = state_q == OPSUM && opsum_valid;
      // left_q counts words still to hand over, so a single read in flight never overshoots
      last = left_q == 5'd1 && (hs || wr);
      rd = stream && left_q != 5'd0 && !pend_q && !full_q;
      state_d = state_q;
      cfg_d = cfg_q;
      fb_d = fb_q;
      ib_d = ib_q;
      pb_d = pb_q;
      ob_d = ob_q;
      fi_d = fi_q + 12'(rd && state_q == FILTER);
      ii_d = ii_q + 12'(rd && state_q == IFMAP);
      pi_d = pi_q + 12'(rd && state_q == IPSUM);
      oi_d = oi_q + 12'(wr);
      left_d = left_q - 5'(hs || wr);
      col_d = col_q;
      pend_d = rd;
      full_d = pend_q || (full_q && !hs);
      buf_d = pend_q ? mem_rdata : buf_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = CFG;
            cfg_d = cfg;
            fb_d = filter_base;
            ib_d = ifmap_base;
            pb_d = ipsum_base;
            ob_d = opsum_base;
            fi_d = '0;
            ii_d = '0;
            pi_d = '0;
            oi_d = '0;
            col_d = '0;
         end
         CFG: begin
            state_d = FILTER;
            left_d = nf;
         end
         FILTER: if (last) begin
            state_d = nc != 5'd0 ? IFMAP : DONE;
            left_d = {2'b0, rs};
         end
         IFMAP: if (last) begin
            state_d = IPSUM;
            left_d = {2'b0, np};
         end
         IPSUM: if (last) begin
            state_d = OPSUM;
            left_d = {2'b0, np};
         end
         OPSUM: if (last) begin
            col_d = col_q + 5'd1;
            state_d = col_q + 5'd1 == nc ? DONE : IFMAP;
            left_d = 5'd1;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         cfg_q <= '0;
         fb_q <= '0;
         ib_q <= '0;
         pb_q <= '0;
         ob_q <= '0;
         fi_q <= '0;
         ii_q <= '0;
         pi_q <= '0;
         oi_q <= '0;
         left_q <= '0;
         col_q <= '0;
         pend_q <= 1'b0;
         full_q <= 1'b0;
         buf_q <= '0;
      end else begin
         state_q <= state_d;
         cfg_q <= cfg_d;
         fb_q <= fb_d;
         ib_q <= ib_d;
         pb_q <= pb_d;
         ob_q <= ob_d;
         fi_q <= fi_d;
         ii_q <= ii_d;
         pi_q <= pi_d;
         oi_q <= oi_d;
         left_q <= left_d;
         col_q <= col_d;
         pend_q <= pend_d;
         full_q <= full_d;
         buf_q <= buf_d;
      end
   assign busy = state_q != IDLE;
   assign done = state_q == DONE;
   assign pe_en = state_q == CFG;
   assign pe_config = cfg_q;
   assign pe_data = buf_q;
   assign mem_rd_en = rd;
   assign mem_raddr = state_q == FILTER ? fb_q + fi_q :
                      state_q == IFMAP  ? ib_q + ii_q :
                      state_q == IPSUM  ? pb_q + pi_q : 12'd0;
   assign filter_valid = state_q == FILTER && full_q;
   assign ifmap_valid = state_q == IFMAP && full_q;
   assign ipsum_valid = state_q == IPSUM && full_q;
   assign opsum_ready = state_q == OPSUM;
   assign mem_we = wr;
   assign mem_waddr = wr ? ob_q + oi_q : 12'd0;
   assign mem_wdata = wr ? opsum : 32'd0;
endmodule

// File: doc/pe_scheduler.md
PE_SCHEDULER -- requirements
Module: pe_scheduler

Interface
REQ-001 SHALL expose ports (name  direction  width  meaning):
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  start-of-job pulse; sampled only in IDLE.
- cfg  in  13  PE config: [12] depthwise, [11:10] rs-1, [9] mode, [8:7] p-1, [6:2] F (column count), [1:0] q-1.
- filter_base, ifmap_base, ipsum_base, opsum_base  in  12 each  word base addresses in GLB.
- busy  out  1  high from start acceptance until DONE exit.
- done  out  1  one-cycle completion pulse.
- mem_rd_en  out  1  GLB read strobe; mem_raddr  out  12; mem_rdata  in  32  valid exactly 1 cycle after mem_rd_en.
- mem_we  out  1  GLB write strobe, always accepted; mem_waddr  out  12; mem_wdata  out  32.
- pe_en  out  1  PE config-latch pulse; pe_config  out  13  held config.
- pe_data  out  32  shared data bus to PE ifmap/filter/ipsum inputs.
- filter_valid, ifmap_valid, ipsum_valid  out  1 each; filter_ready, ifmap_ready, ipsum_ready  in  1 each.
- opsum  in  32; opsum_valid  in  1; opsum_ready  out  1.
REQ-002 SHALL use one clock; reset is asynchronous and active-low (ports clk, rst_n).

Function
REQ-003 SHALL latch cfg and all four bases on start accepted in IDLE; start while busy ignored.
REQ-004 SHALL implement states IDLE, CFG, FILTER, IFMAP, IPSUM, OPSUM, DONE.
REQ-005 IDLE->CFG on start; CFG lasts exactly 1 cycle with pe_en=1, pe_config=latched cfg; CFG->FILTER.
REQ-006 Derived counts: RS=cfg[11:10]+1; NF=(cfg[8:7]+1)*RS; NP=depthwise ? cfg[1:0]+1 : cfg[8:7]+1; NC=cfg[6:2].
REQ-007 FILTER: transfer NF words from filter_base+0..NF-1; then IFMAP if NC>0, else DONE.
REQ-008 IFMAP: column 0 transfers RS words; each later column transfers 1 word; ifmap address pointer advances continuously from ifmap_base; then IPSUM.
REQ-009 IPSUM: transfer NP words; ipsum address advances continuously from ipsum_base across columns; then OPSUM.
REQ-010 OPSUM: opsum_ready=1; each opsum handshake produces mem_we=1 same cycle with mem_wdata=opsum, mem_waddr=opsum_base+running index; after NP handshakes, column count increments; if count==NC ->DONE, else ->IFMAP.
REQ-011 Read streams: at most one read outstanding; issue mem_rd_en only when words remain, no read in flight and 1-entry buffer empty; buffer loads mem_rdata 1 cycle after issue.
REQ-012 Active stream's *_valid SHALL equal buffer-full; other valids 0; pe_data=buffer content; buffer clears on valid&ready.
REQ-013 Stream state exits on the handshake of its last word; no read issued beyond stream length.
REQ-014 DONE lasts 1 cycle: done=1, busy=0 next cycle, ->IDLE.
REQ-015 opsum_valid outside OPSUM SHALL be ignored (no write, opsum_ready=0).
REQ-016 Address arithmetic SHALL wrap modulo 4096.
REQ-017 pe_config SHALL hold its value until next CFG.

Reset
REQ-018 rst_n low SHALL force IDLE; busy, done, pe_en, mem_rd_en, mem_we, all valids, opsum_ready = 0; pe_config, pe_data, addresses = 0.
REQ-019 Reset mid-job SHALL abort immediately; in-flight read data discarded; no write after rst_n asserts.
REQ-020 After rst_n release, first start SHALL run a full job normally.

Verification
REQ-021 cfg rs-1=2,p-1=1,q-1=0,F=2,depthwise=0; PE always ready -> 6 filter reads, 3+1 ifmap reads, 2+2 ipsum reads, 4 writes at opsum_base..+3, done once.
REQ-022 depthwise=1,q-1=3,p-1=0 -> NP=4 ipsum/opsum words per column.
REQ-023 filter_ready low 5 cycles mid-stream -> filter_valid held, pe_data stable, no extra mem_rd_en.
REQ-024 F=0 -> FILTER then DONE, no ifmap/ipsum reads, no writes.
REQ-025 opsum_base=0xFFE, 4 writes -> addresses 0xFFE,0xFFF,0x000,0x001.
REQ-026 rst_n low during IPSUM with read in flight -> all outputs 0 next edge, no write; new start completes correctly.
